// File: rtl/wb_stage.sv
// MEM/WB pipeline register and register-file writeback driver.
// Resolves rt/rd and ALU/load muxes at capture, issues one write per instruction, offers bypass.
module wb_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_reg_write,
    input  logic              in_reg_dst,
    input  logic              in_mem_to_reg,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [4:0]        dec_rs,
    input  logic [4:0]        dec_rt,
    output logic              wb_reg_write,
    output logic [4:0]        wb_write_addr,
    output logic [DATA_W-1:0] wb_write_data,
    output logic              fwd_rs_hit,
    output logic              fwd_rt_hit,
    output logic [DATA_W-1:0] fwd_rs_data,
    output logic [DATA_W-1:0] fwd_rt_data,
    output logic [CNT_W-1:0]  retire_count
);

    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StFresh = 2'd1;
    localparam logic [1:0] StHeld  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              reg_write_q, reg_write_d;
    logic [4:0]        addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              retire;

    always_comb begin
        state_d     = state_q;
        reg_write_d = reg_write_q;
        addr_d      = addr_q;
        data_d      = data_q;
        if (flush || (!stall && !in_valid)) begin
            // Contents are cleared whenever the slot empties so outputs read zero.
            state_d     = StEmpty;
            reg_write_d = 1'b0;
            addr_d      = '0;
            data_d      = '0;
        end else if (!stall) begin
            state_d     = StFresh;
            reg_write_d = in_reg_write;
            addr_d      = in_reg_dst ? in_rd : in_rt;
            data_d      = in_mem_to_reg ? in_mem_data : in_alu_result;
        end else if (state_q != StEmpty) begin
            state_d = StHeld;
        end
    end

    assign retire  = (state_q != StEmpty) && (!stall || flush);
    assign count_d = count_q + CNT_W'(retire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            reg_write_q <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            reg_write_q <= reg_write_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            count_q     <= count_d;
        end
    end

    // Only the first cycle writes; in HELD the register file already has the value.
    assign wb_reg_write  = (state_q == StFresh) && reg_write_q;
    assign wb_write_addr = addr_q;
    assign wb_write_data = data_q;
    assign retire_count  = count_q;

    assign fwd_rs_hit  = wb_reg_write && (addr_q == dec_rs);
    assign fwd_rt_hit  = wb_reg_write && (addr_q == dec_rt);
    assign fwd_rs_data = fwd_rs_hit ? data_q : '0;
    assign fwd_rt_data = fwd_rt_hit ? data_q : '0;

endmodule
